// File: rtl/aes_pkg.sv
// Shared AES definitions: word/byte types, key-size constants, round constants
// and the S-box table used by both the key schedule and the cipher's SubBytes.
package aes_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    localparam int NB = 4;

    localparam int AES128_NK = 4;
    localparam int AES128_NR = 10;
    localparam int AES192_NK = 6;
    localparam int AES192_NR = 12;
    localparam int AES256_NK = 8;
    localparam int AES256_NR = 14;

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_EXPAND = 2'd1,
        KS_DONE   = 2'd2
    } ks_state_e;

    // Key-schedule control state, grouped so a checker can bind to one signal.
    typedef struct packed {
        ks_state_e  state;
        logic [5:0] idx;
        logic [2:0] grp;
        logic [3:0] rcon_idx;
    } ks_ctrl_t;

    // Entry 0 and 11..15 are never selected during a legal expansion.
    localparam byte_t RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam byte_t SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/sub_word.sv
// Four parallel S-box lookups on a 32-bit word; purely combinational.
module sub_word
    import aes_pkg::*;
(
    input  logic [31:0] din,
    output logic [31:0] dout
);

    assign dout = {SBOX[din[31:24]], SBOX[din[23:16]], SBOX[din[15:8]], SBOX[din[7:0]]};

endmodule

// File: rtl/key_expansion_seq.sv
// Sequential AES key schedule: one 32-bit schedule word per cycle into w.
// A sliding window of the last nk words supplies w[i-1] and w[i-nk].
module key_expansion_seq
    import aes_pkg::*;
#(
    parameter int nk = 4,
    parameter int nr = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [nk*32-1:0]           key,
    output logic                       busy,
    output logic                       w_valid,
    output logic [0:((nr+1)*128)-1]    w
);

    localparam int         NW       = NB * (nr + 1);
    localparam int         WBITS    = NW * 32;
    localparam logic [5:0] LAST_IDX = 6'(NW - 1);
    localparam logic [2:0] GRP_LAST = 3'(nk - 1);

    // Handshake: start is honoured only when busy=0 (IDLE or DONE) and is a
    // one-cycle request; busy stays high until the edge that writes the last
    // word, on which w_valid rises and stays until the next accepted start.

    ks_ctrl_t         ctrl_q, ctrl_d;
    logic             busy_q, busy_d;
    logic             w_valid_q, w_valid_d;
    logic [0:WBITS-1] w_q, w_d;
    word_t            win_q [0:nk-1];
    word_t            win_d [0:nk-1];

    word_t prev_word;
    word_t sw_in;
    word_t sw_out;
    word_t temp;
    word_t new_word;

    sub_word u_sub_word (
        .din  (sw_in),
        .dout (sw_out)
    );

    always_comb begin
        prev_word = win_q[nk-1];
        sw_in     = (ctrl_q.grp == 3'd0) ? rot_word(prev_word) : prev_word;
        if (ctrl_q.grp == 3'd0) begin
            temp = sw_out ^ {RCON[ctrl_q.rcon_idx], 24'h0};
        end else if (nk == 8 && ctrl_q.grp == 3'd4) begin
            temp = sw_out;
        end else begin
            temp = prev_word;
        end
        new_word = win_q[0] ^ temp;
    end

    always_comb begin
        ctrl_d    = ctrl_q;
        busy_d    = busy_q;
        w_valid_d = w_valid_q;
        w_d       = w_q;
        win_d     = win_q;

        case (ctrl_q.state)
            KS_IDLE, KS_DONE: begin
                if (start) begin
                    for (int j = 0; j < nk; j++) begin
                        win_d[j]          = key[(nk-1-j)*32 +: 32];
                        w_d[j*32 +: 32]   = key[(nk-1-j)*32 +: 32];
                    end
                    ctrl_d.state    = KS_EXPAND;
                    ctrl_d.idx      = 6'(nk);
                    ctrl_d.grp      = 3'd0;
                    ctrl_d.rcon_idx = 4'd1;
                    busy_d          = 1'b1;
                    w_valid_d       = 1'b0;
                end
            end
            KS_EXPAND: begin
                for (int j = 0; j < NW; j++) begin
                    if (ctrl_q.idx == 6'(j)) begin
                        w_d[j*32 +: 32] = new_word;
                    end
                end
                for (int j = 0; j < nk - 1; j++) begin
                    win_d[j] = win_q[j+1];
                end
                win_d[nk-1] = new_word;
                ctrl_d.idx  = ctrl_q.idx + 6'd1;
                // grp tracks i%nk; rcon_idx tracks i/nk for the next group.
                if (ctrl_q.grp == GRP_LAST) begin
                    ctrl_d.grp      = 3'd0;
                    ctrl_d.rcon_idx = ctrl_q.rcon_idx + 4'd1;
                end else begin
                    ctrl_d.grp = ctrl_q.grp + 3'd1;
                end
                if (ctrl_q.idx == LAST_IDX) begin
                    ctrl_d.state = KS_DONE;
                    busy_d       = 1'b0;
                    w_valid_d    = 1'b1;
                end
            end
            default: begin
                ctrl_d.state = KS_IDLE;
                busy_d       = 1'b0;
                w_valid_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q    <= '{state: KS_IDLE, idx: 6'd0, grp: 3'd0, rcon_idx: 4'd0};
            busy_q    <= 1'b0;
            w_valid_q <= 1'b0;
            w_q       <= '0;
            for (int j = 0; j < nk; j++) begin
                win_q[j] <= '0;
            end
        end else begin
            ctrl_q    <= ctrl_d;
            busy_q    <= busy_d;
            w_valid_q <= w_valid_d;
            w_q       <= w_d;
            for (int j = 0; j < nk; j++) begin
                win_q[j] <= win_d[j];
            end
        end
    end

    assign busy    = busy_q;
    assign w_valid = w_valid_q;
    assign w       = w_q;

endmodule

// File: tb/tb_key_expansion_seq.sv
// Directed bench for key_expansion_seq against FIPS-197 key schedules for
// all three key sizes, plus ignored-start, abort, reload and stability cases.
module tb_key_expansion_seq;

    localparam logic [255:0] K128 = {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    localparam logic [255:0] K192 = {64'h0, 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic clk = 1'b0;
    logic reset;
    logic start4, start6, start8;
    logic [127:0] key4;
    logic [191:0] key6;
    logic [255:0] key8;
    logic busy4, busy6, busy8;
    logic wv4, wv6, wv8;
    logic [0:44*32-1] w4;
    logic [0:52*32-1] w6;
    logic [0:60*32-1] w8;

    int   total = 0;
    int   bad   = 0;
    int   sel   = 4;
    int   lat;
    logic cur_busy, cur_valid;

    always #5 clk = ~clk;

    key_expansion_seq #(.nk(4), .nr(10)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .key(key4),
        .busy(busy4), .w_valid(wv4), .w(w4)
    );
    key_expansion_seq #(.nk(6), .nr(12)) dut6 (
        .clk(clk), .reset(reset), .start(start6), .key(key6),
        .busy(busy6), .w_valid(wv6), .w(w6)
    );
    key_expansion_seq #(.nk(8), .nr(14)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .key(key8),
        .busy(busy8), .w_valid(wv8), .w(w8)
    );

    always_comb begin
        cur_busy  = busy4;
        cur_valid = wv4;
        if (sel == 6) begin
            cur_busy  = busy6;
            cur_valid = wv6;
        end else if (sel == 8) begin
            cur_busy  = busy8;
            cur_valid = wv8;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word4(input int i);
        return w4[i*32 +: 32];
    endfunction

    function automatic logic [127:0] last4();
        return w4[40*32 +: 128];
    endfunction

    // Drives a one-cycle start on the selected instance and checks acceptance.
    task automatic pulse(input int which, input logic [255:0] k);
        sel = which;
        @(negedge clk);
        case (which)
            4: begin start4 = 1'b1; key4 = k[127:0]; end
            6: begin start6 = 1'b1; key6 = k[191:0]; end
            default: begin start8 = 1'b1; key8 = k; end
        endcase
        @(posedge clk);
        #1;
        start4 = 1'b0;
        start6 = 1'b0;
        start8 = 1'b0;
        chk("accept_busy", {127'b0, cur_busy}, 128'd1);
        chk("accept_wv_low", {127'b0, cur_valid}, 128'd0);
    endtask

    // Counts edges after the accepting edge until w_valid; 0 means timeout.
    task automatic wait_done(input int pulse_at, input bit churn, output int n);
        n = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            start4 = 1'b0;
            if (churn) begin
                key4 = {$urandom, $urandom, $urandom, $urandom};
            end
            if (cur_valid) begin
                n = c;
                break;
            end
            if (c == pulse_at) begin
                start4 = 1'b1;
                key4   = '0;
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        start4 = 1'b0;
        start6 = 1'b0;
        start8 = 1'b0;
        key4   = '0;
        key6   = '0;
        key8   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_w_zero", {127'b0, |w4}, 128'd0);
        chk("rst_wv", {127'b0, wv4}, 128'd0);
        chk("rst_busy", {127'b0, busy4}, 128'd0);
        @(negedge clk);
        reset = 1'b0;

        pulse(4, K128);
        wait_done(-1, 1'b0, lat);
        chk("aes128_latency", 128'(lat), 128'd40);
        chk("aes128_w4", {96'b0, word4(4)}, {96'b0, 32'ha0fafe17});
        chk("aes128_last", last4(), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("aes128_busy_done", {127'b0, busy4}, 128'd0);

        pulse(6, K192);
        wait_done(-1, 1'b0, lat);
        chk("aes192_latency", 128'(lat), 128'd46);
        chk("aes192_w6", {96'b0, w6[6*32 +: 32]}, {96'b0, 32'hfe0c91f7});
        chk("aes192_w51", {96'b0, w6[51*32 +: 32]}, {96'b0, 32'h01002202});

        pulse(8, K256);
        wait_done(-1, 1'b0, lat);
        chk("aes256_latency", 128'(lat), 128'd52);
        chk("aes256_w12", {96'b0, w8[12*32 +: 32]}, {96'b0, 32'ha8b09c1a});
        chk("aes256_w59", {96'b0, w8[59*32 +: 32]}, {96'b0, 32'h706c631e});

        pulse(4, K128);
        wait_done(10, 1'b0, lat);
        chk("ignored_start_latency", 128'(lat), 128'd40);
        chk("ignored_start_last", last4(), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("ignored_start_w4", {96'b0, word4(4)}, {96'b0, 32'ha0fafe17});

        pulse(4, 256'h0);
        wait_done(-1, 1'b0, lat);
        chk("zero_key_latency", 128'(lat), 128'd40);
        chk("zero_key_w4", {96'b0, word4(4)}, {96'b0, 32'h62636363});
        chk("zero_key_last", last4(), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        pulse(4, K128);
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_w_zero", {127'b0, |w4}, 128'd0);
        chk("abort_wv", {127'b0, wv4}, 128'd0);
        chk("abort_busy", {127'b0, busy4}, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        pulse(4, K128);
        wait_done(-1, 1'b0, lat);
        chk("after_abort_latency", 128'(lat), 128'd40);
        chk("after_abort_last", last4(), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        pulse(4, K128);
        wait_done(-1, 1'b1, lat);
        chk("churn_latency", 128'(lat), 128'd40);
        chk("churn_last", last4(), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            key4 = {$urandom, $urandom, $urandom, $urandom};
            chk("hold_wv", {127'b0, wv4}, 128'd1);
            chk("hold_last", last4(), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
            chk("hold_w4", {96'b0, word4(4)}, {96'b0, 32'ha0fafe17});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
